// File: rtl/fifo_drain_display.sv
// Read-side FIFO controller: pops on a start edge or at a fixed dwell pace, shifts each
// captured entry into a 16-bit display register and keeps a pop count and underflow flag.
module fifo_drain_display #(
    parameter int unsigned B         = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned DWELL_CYC = 50000000,
    parameter int unsigned DW        = 26
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic         i_auto_en,
    input  logic         i_empty,
    input  logic [B-1:0] i_r_data,
    output logic         o_rd,
    output logic [15:0]  o_disp_value,
    output logic         o_valid,
    output logic [7:0]   o_pop_count,
    output logic         o_underflow,
    output logic         o_busy
);

    localparam int unsigned LW = 2;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StCapture,
        StDwell
    } state_t;

    state_t         r_state;
    logic           r_start_d;
    logic [LW-1:0]  r_lat;
    logic [DW-1:0]  r_dwell;
    logic           r_rd;
    logic [15:0]    r_disp;
    logic           r_valid;
    logic [7:0]     r_pop_count;
    logic           r_underflow;
    logic           r_busy;

    logic           w_req;
    logic [15:0]    w_disp_next;

    assign w_req = i_start & ~r_start_d;

    // A full-width entry replaces the whole display instead of shifting.
    if (B == 16) begin : g_full
        assign w_disp_next = i_r_data;
    end else begin : g_shift
        assign w_disp_next = {r_disp[15-B:0], i_r_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= StIdle;
            r_start_d   <= 1'b0;
            r_lat       <= '0;
            r_dwell     <= '0;
            r_rd        <= 1'b0;
            r_disp      <= '0;
            r_valid     <= 1'b0;
            r_pop_count <= '0;
            r_underflow <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start_d   <= i_start;
            r_rd        <= 1'b0;
            r_underflow <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!i_empty && (i_auto_en || w_req)) begin
                        r_state <= StPop;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_req && i_empty && !i_auto_en) begin
                        r_underflow <= 1'b1;
                    end
                end
                StPop: begin
                    r_lat <= LW'(RD_LAT - 1);
                    if (RD_LAT == 1) r_state <= StCapture;
                    else             r_state <= StWait;
                end
                StWait: begin
                    r_lat <= r_lat - LW'(1);
                    if (r_lat == LW'(1)) r_state <= StCapture;
                end
                StCapture: begin
                    r_disp      <= w_disp_next;
                    r_pop_count <= r_pop_count + 8'd1;
                    r_valid     <= 1'b1;
                    r_dwell     <= '0;
                    if (i_auto_en) begin
                        r_state <= StDwell;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StDwell: begin
                    // Leaving auto mode or running dry ends the dwell early.
                    if (!i_auto_en || i_empty || r_dwell == DW'(DWELL_CYC - 1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd         = r_rd;
    assign o_disp_value = r_disp;
    assign o_valid      = r_valid;
    assign o_pop_count  = r_pop_count;
    assign o_underflow  = r_underflow;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_fifo_drain_display.sv
// Bench for fifo_drain_display: directed vector table, hand sequences for multi-cycle
// corners, and randomized traffic checked against a timestamp-based reference model.
module tb_fifo_drain_display;

    localparam int unsigned B         = 8;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned DWELL_CYC = 4;
    localparam int unsigned DW        = 3;
    localparam int          INF       = 32'h3fff_ffff;

    logic         clk = 1'b0;
    logic         i_clr = 1'b1;
    logic         i_start = 1'b0;
    logic         i_auto_en = 1'b0;
    logic         i_empty = 1'b1;
    logic [B-1:0] i_r_data = '0;
    logic         o_rd;
    logic [15:0]  o_disp_value;
    logic         o_valid;
    logic [7:0]   o_pop_count;
    logic         o_underflow;
    logic         o_busy;

    always #5 clk = ~clk;

    fifo_drain_display #(
        .B         (B),
        .RD_LAT    (RD_LAT),
        .DWELL_CYC (DWELL_CYC),
        .DW        (DW)
    ) u_dut (
        .i_clk        (clk),
        .i_clr        (i_clr),
        .i_start      (i_start),
        .i_auto_en    (i_auto_en),
        .i_empty      (i_empty),
        .i_r_data     (i_r_data),
        .o_rd         (o_rd),
        .o_disp_value (o_disp_value),
        .o_valid      (o_valid),
        .o_pop_count  (o_pop_count),
        .o_underflow  (o_underflow),
        .o_busy       (o_busy)
    );

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {4'h0, o_rd, o_underflow, o_busy, o_valid, o_pop_count, o_disp_value};
    endfunction

    // FIFO stand-in: data is only valid RD_LAT cycles after the strobe, junk otherwise.
    logic [7:0] byte_q[$];
    logic [7:0] m_q[$];
    logic [7:0] pipe_val = '0;
    int         pipe_cnt = 0;

    task automatic fifo_service();
        if (pipe_cnt > 0) begin
            pipe_cnt--;
            i_r_data = (pipe_cnt == 0) ? pipe_val : ~pipe_val;
        end else begin
            i_r_data = ~pipe_val;
        end
        if (o_rd === 1'b1) begin
            pipe_val = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hBD;
            pipe_cnt = RD_LAT;
        end
        i_empty = (byte_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] v);
        byte_q.push_back(v);
        m_q.push_back(v);
        i_empty = 1'b0;
    endtask

    task automatic cycle(input logic clr, input logic start, input logic auto_en);
        i_clr     = clr;
        i_start   = start;
        i_auto_en = auto_en;
        @(negedge clk);
        fifo_service();
        tb_cyc++;
    endtask

    // Reference model: tracks absolute cycle numbers of the rd strobe, the capture and the
    // end of the dwell window, and derives the expected outputs from them.
    logic        m_en = 1'b0;
    int          m_cyc = 0;
    int          m_free_at = INF;
    int          m_rd_at = -1;
    int          m_cap_at = -1;
    int          m_dwell_hi = -1;
    logic [7:0]  m_pend = '0;
    logic        m_prev = 1'b0;
    logic        e_rd = 1'b0, e_uf = 1'b0, e_busy = 1'b0, e_valid = 1'b0;
    logic [7:0]  e_cnt = '0;
    logic [15:0] e_disp = '0;

    always @(posedge clk) begin : model
        int   n;
        logic req;
        m_cyc++;
        n    = m_cyc;
        e_uf = 1'b0;
        if (i_clr) begin
            m_en       = 1'b1;
            m_free_at  = n;
            m_rd_at    = -1;
            m_cap_at   = -1;
            m_dwell_hi = -1;
            e_disp     = '0;
            e_valid    = 1'b0;
            e_cnt      = '0;
            m_prev     = 1'b0;
        end else begin
            req = i_start && !m_prev;
            if (n - 1 >= m_free_at) begin
                if (!i_empty && (i_auto_en || req)) begin
                    m_rd_at    = n;
                    m_cap_at   = n + RD_LAT;
                    m_dwell_hi = -1;
                    m_free_at  = INF;
                    m_pend     = (m_q.size() > 0) ? m_q.pop_front() : 8'h00;
                end else if (req && i_empty && !i_auto_en) begin
                    e_uf = 1'b1;
                end
            end else if (n == m_cap_at + 1) begin
                e_disp  = {e_disp[7:0], m_pend};
                e_cnt   = e_cnt + 8'd1;
                e_valid = 1'b1;
                if (i_auto_en) m_dwell_hi = n + DWELL_CYC - 1;
                else           m_free_at  = n;
            end else if (n - 1 > m_cap_at && n - 1 <= m_dwell_hi) begin
                if (!i_auto_en || i_empty || n - 1 == m_dwell_hi) m_free_at = n;
            end
            m_prev = i_start;
        end
        e_rd   = (n == m_rd_at);
        e_busy = (n < m_free_at);
    end

    always @(negedge clk) begin
        if (m_en) chk("model", outs(), {4'h0, e_rd, e_uf, e_busy, e_valid, e_cnt, e_disp});
    end

    typedef struct {
        logic        clr, start, auto_en;
        logic        rd, uf, busy, valid;
        logic [7:0]  cnt;
        logic [15:0] disp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int rd_n, uf_n, g1, g2;
        int rd_at[$];
        logic a;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 16'h003A};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 16'h003A};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 16'h003A};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 16'h003A};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h3AC5};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 16'h3AC5};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h3AC5};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h3AC5};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 16'h3AC5};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'h3AC5};

        // Manual pops of 0x3A, 0xC5 then underflow attempts on an empty FIFO.
        cycle(1'b1, 1'b0, 1'b0);
        push(8'h3A);
        push(8'hC5);
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].clr, tbl[i].start, tbl[i].auto_en);
            chk($sformatf("vec%0d", i), outs(), {4'h0, tbl[i].rd, tbl[i].uf, tbl[i].busy,
                tbl[i].valid, tbl[i].cnt, tbl[i].disp});
        end

        // Held start gives one pop; an edge during WAIT/CAPTURE is dropped.
        cycle(1'b1, 1'b0, 1'b0);
        push(8'h5C);
        push(8'h6D);
        push(8'h7E);
        rd_n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            rd_n += int'(o_rd);
        end
        chk("held_start_rd", rd_n, 1);
        cycle(1'b0, 1'b0, 1'b0);
        rd_n = 0;
        cycle(1'b0, 1'b1, 1'b0);
        rd_n += int'(o_rd);
        cycle(1'b0, 1'b0, 1'b0);
        rd_n += int'(o_rd);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            rd_n += int'(o_rd);
        end
        chk("dropped_edge_rd", rd_n, 1);
        chk("dropped_edge_cnt", o_pop_count, 2);
        chk("dropped_edge_disp", o_disp_value, 16'h5C6D);

        // Reset during WAIT discards the in-flight entry.
        cycle(1'b1, 1'b0, 1'b0);
        byte_q.delete();
        m_q.delete();
        push(8'h99);
        cycle(1'b0, 1'b1, 1'b0);
        chk("midrst_rd", o_rd, 1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("midrst_busy", o_busy, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("midrst_disp", o_disp_value, 16'h0000);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_cnt", o_pop_count, 0);

        // Auto drain: rd every RD_LAT+DWELL_CYC+2 cycles, quiet once empty.
        cycle(1'b1, 1'b0, 1'b0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        uf_n = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (o_rd) rd_at.push_back(tb_cyc);
            uf_n += int'(o_underflow);
        end
        chk("auto_rd_count", rd_at.size(), 3);
        g1 = (rd_at.size() >= 2) ? rd_at[1] - rd_at[0] : 0;
        g2 = (rd_at.size() >= 3) ? rd_at[2] - rd_at[1] : 0;
        chk("auto_gap1", g1, RD_LAT + DWELL_CYC + 2);
        chk("auto_gap2", g2, RD_LAT + DWELL_CYC + 2);
        chk("auto_disp", o_disp_value, 16'h2233);
        chk("auto_cnt", o_pop_count, 3);
        chk("auto_uf", uf_n, 0);
        chk("auto_busy", o_busy, 0);

        // Dropping auto_en mid-dwell returns to IDLE; a start edge then pops one entry.
        cycle(1'b1, 1'b0, 1'b0);
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("abort_busy", o_busy, 0);
        chk("abort_disp", o_disp_value, 16'h00A1);
        rd_n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            rd_n += int'(o_rd);
        end
        chk("abort_no_rd", rd_n, 0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("abort_start_rd", o_rd, 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("abort_start_disp", o_disp_value, 16'hA1B2);

        // Pop count wraps 255 -> 0.
        cycle(1'b1, 1'b0, 1'b0);
        byte_q.delete();
        m_q.delete();
        for (int i = 0; i < 255; i++) begin
            push(8'(i));
            cycle(1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0);
        end
        chk("wrap_255", o_pop_count, 255);
        push(8'h4F);
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0);
        chk("wrap_0", o_pop_count, 0);
        chk("wrap_valid", o_valid, 1);
        chk("wrap_disp", o_disp_value, 16'hFE4F);

        // Random traffic against the model.
        cycle(1'b1, 1'b0, 1'b0);
        a = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && byte_q.size() < 12) push(8'($urandom));
            if ($urandom_range(0, 39) == 0) a = ~a;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0) ? ~i_start : i_start,
                  a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
